// File: rtl/obi_line_arbiter.sv
// rtl/obi_line_arbiter.sv - round-robin cache-line arbiter serializing lines onto one OBI master
//
// Accepts line requests from NUM_CH cache channels, grants one at a time in
// round-robin order, splits the line into LINE_WIDTH/32 OBI beats (pipelined,
// in order), gathers read data and returns the whole line to the requester.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_req_*             per-channel line request (valid/ready, rw, addr, byteen, data, tag)
//   in_rsp_*             read line response (one-hot valid per channel, shared data/tag)
//   obi_*                shared OBI master port (req/gnt address phase, rvalid/rdata response)
//
// Build option:
//   OBI_LINE_ARB_WSKIP_EN  when defined, write beats with all-zero byte enables
//                          are skipped instead of being issued on OBI.

module obi_line_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int LINE_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              in_req_valid,
  output logic [NUM_CH-1:0]              in_req_ready,
  input  logic [NUM_CH-1:0]              in_req_rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_CH*LINE_WIDTH/8-1:0] in_req_byteen,
  input  logic [NUM_CH*LINE_WIDTH-1:0]   in_req_data,
  input  logic [NUM_CH*TAG_WIDTH-1:0]    in_req_tag,
  output logic [NUM_CH-1:0]              in_rsp_valid,
  input  logic [NUM_CH-1:0]              in_rsp_ready,
  output logic [LINE_WIDTH-1:0]          in_rsp_data,
  output logic [TAG_WIDTH-1:0]           in_rsp_tag,
  output logic                           obi_req_o,
  output logic                           obi_we_o,
  output logic [31:0]                    obi_addr_o,
  output logic [3:0]                     obi_be_o,
  output logic [31:0]                    obi_wdata_o,
  input  logic                           obi_gnt_i,
  input  logic                           obi_rvalid_i,
  input  logic [31:0]                    obi_rdata_i
);

  localparam int BEATS = LINE_WIDTH / 32;
  localparam int LB    = $clog2(LINE_WIDTH / 8);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(BEATS + 1);
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FAW   = ADDR_WIDTH + LB;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                 state;
  logic [CW-1:0]              rr;
  logic [CW-1:0]              ch_q;
  logic                       rw_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [BEATS-1:0][3:0]      be_q;
  logic [BEATS-1:0][31:0]     data_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic [BEATS-1:0][31:0]     rbuf;
  logic [BW-1:0]              issue_cnt;
  logic [PW-1:0]              pend_cnt;
  logic [BW-1:0]              rsp_cnt;

  logic                       gnt_found;
  logic [CW-1:0]              gnt_idx;
  logic                       in_issue;
  logic                       beat_skip;
  logic                       obi_hs;
  logic                       advance;
  logic                       rv;
  logic                       drain_done;
  logic [FAW-1:0]             full_addr;

  // First valid channel at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_found && in_req_valid[(int'(rr) + i) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'((int'(rr) + i) % NUM_CH);
      end
    end
  end

  // Gated by rst_ni so the request handshake is quiet while reset is held.
  assign in_req_ready = (rst_ni && state == S_IDLE && gnt_found) ? (NUM_CH'(1) << gnt_idx) : '0;

  assign in_issue = (state == S_ISSUE);

`ifdef OBI_LINE_ARB_WSKIP_EN
  assign beat_skip = in_issue && rw_q && (be_q[issue_cnt] == 4'h0);
`else
  assign beat_skip = 1'b0;
`endif

  // Address, data and enables depend only on issue_cnt, which moves on a grant
  // (or a skip), so they stay stable while a request waits for gnt.
  assign full_addr   = (FAW'(addr_q) << LB) | (FAW'(issue_cnt) << 2);
  assign obi_req_o   = in_issue && !beat_skip;
  assign obi_we_o    = obi_req_o && rw_q;
  assign obi_addr_o  = obi_req_o ? 32'(full_addr) : 32'h0;
  assign obi_wdata_o = obi_req_o ? data_q[issue_cnt] : 32'h0;
  assign obi_be_o    = !obi_req_o ? 4'h0 : (rw_q ? be_q[issue_cnt] : 4'hF);

  assign obi_hs  = obi_req_o && obi_gnt_i;
  assign advance = obi_hs || beat_skip;
  assign rv      = obi_rvalid_i && (state == S_ISSUE || state == S_DRAIN);

  // The final response may land in the cycle DRAIN exits; it is written to the
  // buffer on that same edge, so the line is complete when RESP starts.
  assign drain_done = (pend_cnt == PW'(rv));

  assign in_rsp_valid = (state == S_RESP) ? (NUM_CH'(1) << ch_q) : '0;
  assign in_rsp_data  = (state == S_RESP) ? rbuf : '0;
  assign in_rsp_tag   = (state == S_RESP) ? tag_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      rr        <= '0;
      ch_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      rbuf      <= '0;
      issue_cnt <= '0;
      pend_cnt  <= '0;
      rsp_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            ch_q      <= gnt_idx;
            rw_q      <= in_req_rw[gnt_idx];
            addr_q    <= in_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            be_q      <= in_req_byteen[gnt_idx*(LINE_WIDTH/8) +: LINE_WIDTH/8];
            data_q    <= in_req_data[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
            tag_q     <= in_req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
            rr        <= (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            issue_cnt <= '0;
            pend_cnt  <= '0;
            rsp_cnt   <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (advance && issue_cnt == BW'(BEATS - 1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) state <= rw_q ? S_IDLE : S_RESP;
        end
        S_RESP: begin
          if (in_rsp_ready[ch_q]) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (state != S_IDLE) begin
        issue_cnt <= issue_cnt + BW'(advance);
        pend_cnt  <= pend_cnt + PW'(obi_hs) - PW'(rv);
        rsp_cnt   <= rsp_cnt + BW'(rv);
        if (rv && !rw_q) rbuf[rsp_cnt] <= obi_rdata_i;
      end
    end
  end

endmodule
